// File: rtl/bsg_nor2_operand_join.sv
// Operand join stage: buffers A and B operands in independent 2-entry FIFOs and
// presents aligned A/B pairs to the downstream NOR on a valid/yumi handshake.
module bsg_nor2_operand_join #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               a_v_i,
  input  logic [width_p-1:0] a_data_i,
  output logic               a_ready_o,
  input  logic               b_v_i,
  input  logic [width_p-1:0] b_data_i,
  output logic               b_ready_o,
  output logic               v_o,
  output logic [width_p-1:0] a_o,
  output logic [width_p-1:0] b_o,
  input  logic               yumi_i,
  output logic [1:0]         a_count_o,
  output logic [1:0]         b_count_o
);

  logic               ready_en_q;
  logic [width_p-1:0] a_mem_q [2];
  logic [width_p-1:0] b_mem_q [2];
  logic               a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic               b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic [1:0]         a_count_q, a_count_d;
  logic [1:0]         b_count_q, b_count_d;
  logic               a_enq, b_enq, deq;

  // Ready is held low during reset and rises on the first edge after release.
  assign a_ready_o = ready_en_q & (a_count_q != 2'd2);
  assign b_ready_o = ready_en_q & (b_count_q != 2'd2);
  assign v_o       = (a_count_q != 2'd0) & (b_count_q != 2'd0);
  assign a_o       = a_mem_q[a_rptr_q];
  assign b_o       = b_mem_q[b_rptr_q];
  assign a_count_o = a_count_q;
  assign b_count_o = b_count_q;

  assign a_enq = a_v_i & a_ready_o;
  assign b_enq = b_v_i & b_ready_o;
  // A yumi without a valid pair is dropped.
  assign deq   = yumi_i & v_o;

  always_comb begin
    a_wptr_d  = a_wptr_q ^ a_enq;
    a_rptr_d  = a_rptr_q ^ deq;
    a_count_d = a_count_q;
    if (a_enq && !deq) begin
      a_count_d = a_count_q + 2'd1;
    end else if (!a_enq && deq) begin
      a_count_d = a_count_q - 2'd1;
    end
  end

  always_comb begin
    b_wptr_d  = b_wptr_q ^ b_enq;
    b_rptr_d  = b_rptr_q ^ deq;
    b_count_d = b_count_q;
    if (b_enq && !deq) begin
      b_count_d = b_count_q + 2'd1;
    end else if (!b_enq && deq) begin
      b_count_d = b_count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_en_q <= 1'b0;
      a_wptr_q   <= 1'b0;
      a_rptr_q   <= 1'b0;
      a_count_q  <= 2'd0;
      b_wptr_q   <= 1'b0;
      b_rptr_q   <= 1'b0;
      b_count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      a_wptr_q   <= a_wptr_d;
      a_rptr_q   <= a_rptr_d;
      a_count_q  <= a_count_d;
      b_wptr_q   <= b_wptr_d;
      b_rptr_q   <= b_rptr_d;
      b_count_q  <= b_count_d;
      if (a_enq) begin
        a_mem_q[a_wptr_q] <= a_data_i;
      end
      if (b_enq) begin
        b_mem_q[b_wptr_q] <= b_data_i;
      end
    end
  end

endmodule

// File: tb/tb_bsg_nor2_operand_join.sv
// Directed and randomized bench for bsg_nor2_operand_join against a queue-based model.
module tb_bsg_nor2_operand_join;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        a_v_i, b_v_i, yumi_i;
  logic [15:0] a_data_i, b_data_i;
  logic        a_ready_o, b_ready_o, v_o;
  logic [15:0] a_o, b_o;
  logic [1:0]  a_count_o, b_count_o;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] aq[$];
  logic [15:0] bq[$];
  bit          rdy_en = 1'b0;

  bsg_nor2_operand_join #(.width_p(16)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .a_v_i     (a_v_i),
    .a_data_i  (a_data_i),
    .a_ready_o (a_ready_o),
    .b_v_i     (b_v_i),
    .b_data_i  (b_data_i),
    .b_ready_o (b_ready_o),
    .v_o       (v_o),
    .a_o       (a_o),
    .b_o       (b_o),
    .yumi_i    (yumi_i),
    .a_count_o (a_count_o),
    .b_count_o (b_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_v();
    return (aq.size() > 0) && (bq.size() > 0);
  endfunction

  task automatic check_state();
    check("v_o", {31'd0, v_o}, {31'd0, model_v()});
    check("a_count", {30'd0, a_count_o}, aq.size());
    check("b_count", {30'd0, b_count_o}, bq.size());
    check("a_ready", {31'd0, a_ready_o}, {31'd0, rdy_en && aq.size() < 2});
    check("b_ready", {31'd0, b_ready_o}, {31'd0, rdy_en && bq.size() < 2});
    if (model_v()) begin
      check("a_head", {16'd0, a_o}, {16'd0, aq[0]});
      check("b_head", {16'd0, b_o}, {16'd0, bq[0]});
    end
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, then compare.
  task automatic step(input logic av, input logic [15:0] ad, input logic bv,
                      input logic [15:0] bd, input logic y);
    bit a_acc, b_acc, deq;
    logic [15:0] tmp;
    a_v_i = av; a_data_i = ad; b_v_i = bv; b_data_i = bd; yumi_i = y;
    if (y) check("yumi_legal", {31'd0, v_o}, 32'd1);
    a_acc = av && rdy_en && aq.size() < 2;
    b_acc = bv && rdy_en && bq.size() < 2;
    deq   = y && model_v();
    @(posedge clk);
    #1;
    if (deq) begin
      tmp = aq.pop_front();
      tmp = bq.pop_front();
    end
    if (a_acc) aq.push_back(ad);
    if (b_acc) bq.push_back(bd);
    rdy_en = 1'b1;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_v"}, {31'd0, v_o}, 32'd0);
    check({tag, "_acnt"}, {30'd0, a_count_o}, 32'd0);
    check({tag, "_bcnt"}, {30'd0, b_count_o}, 32'd0);
    check({tag, "_a_o"}, {16'd0, a_o}, 32'd0);
    check({tag, "_b_o"}, {16'd0, b_o}, 32'd0);
    check({tag, "_ardy"}, {31'd0, a_ready_o}, 32'd0);
    check({tag, "_brdy"}, {31'd0, b_ready_o}, 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string tag);
    #3 reset_n_i = 1'b0;
    aq.delete();
    bq.delete();
    rdy_en = 1'b0;
    #1 check_reset_state(tag);
    #1 reset_n_i = 1'b1;
    check_reset_state({tag, "_rel"});
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (aq.size() > 0 || bq.size() > 0); i++) begin
      step(aq.size() < bq.size(), 16'h1000 + 16'(i), bq.size() < aq.size(),
           16'h2000 + 16'(i), model_v());
    end
    check("drained", aq.size() + bq.size(), 32'd0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    a_v_i = 1'b0; b_v_i = 1'b0; yumi_i = 1'b0;
    a_data_i = '0; b_data_i = '0;
    @(posedge clk);
    #1 check_reset_state("por");
    @(posedge clk);
    #1 reset_n_i = 1'b1;
    check_reset_state("por_rel");
    idle();  // readies rise here

    // Skewed arrival
    step(1'b1, 16'h00FF, 1'b0, 16'h0, 1'b0);
    idle();
    idle();
    step(1'b0, 16'h0, 1'b1, 16'h0F0F, 1'b0);
    check("skew_nor", {16'd0, ~(a_o | b_o)}, 32'h0000_F000);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    // One side full, with a held third A
    step(1'b1, 16'h0001, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0003, 1'b1, 16'hFFFF, 1'b0);
    check("full_pair_a", {16'd0, a_o}, 32'h0001);
    step(1'b1, 16'h0003, 1'b0, 16'h0, 1'b1);
    check("full_recover_cnt", {30'd0, a_count_o}, 32'd1);
    step(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0);
    check("full_third_in", {30'd0, a_count_o}, 32'd2);
    drain();

    // Streaming with yumi = v
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(i), 1'b1, 16'(i), model_v());
    end
    step(1'b0, 16'h0, 1'b0, 16'h0, model_v());

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h0A00 + 16'(i), 1'b1, 16'h0B00 + 16'(i), 1'b0);
    end
    check("bp_a_head", {16'd0, a_o}, 32'h0A00);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    check("bp_a_second", {16'd0, a_o}, 32'h0A01);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    // Reset mid-traffic
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h5500 + 16'(i), 1'b1, 16'h6600 + 16'(i), model_v());
    end
    reset_pulse("midrst");
    step(1'b1, 16'h7700, 1'b1, 16'h8800, 1'b0);
    step(1'b1, 16'h7701, 1'b1, 16'h8801, 1'b0);
    check("postrst_a", {16'd0, a_o}, 32'h7701);
    check("postrst_b", {16'd0, b_o}, 32'h8801);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
           model_v() && 1'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
